mem_stage_ctrl: RTL

Memory-stage controller for the five-stage pipeline: consumes the registered EX/MEM bundle, drives the stallable data memory (request/stall/done handshake) and produces the registered MEM/WB bundle. Each memory access is issued exactly once. `stall_o` freezes PC, IF/ID, ID/EX and EX/MEM until the access completes. Misaligned accesses and memory timeouts are reported on `err_o`.

---
 rtl/wisc_pkg.sv | 23 ++
 rtl/pipe_MEM_WB.sv | 32 +++
 rtl/mem_stage_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the memory stage: controller state encoding, default
// timeout, and the MEM/WB pipeline bundle layout.
package wisc_pkg;

   localparam int unsigned MAX_WAIT_DEF = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01
   } state_e;

   // 16 + 16 + 3 + 4 bits carried from MEM to WB
   typedef struct packed {
      logic [15:0] rdata;
      logic [15:0] alu;
      logic [2:0]  dst;
      logic        reg_write;
      logic        mem_reg;
      logic        halt;
      logic        err;
   } mem_wb_t;

endpackage

// File: rtl/pipe_MEM_WB.sv
// MEM/WB pipeline register: a plain flop bank with a bubble-select mux in
// front, so a stalled memory stage hands WB an all-zero (no-op) bundle.
module pipe_MEM_WB
   import wisc_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    bubble_i,
   input  mem_wb_t d_i,
   output mem_wb_t q_o
);

   mem_wb_t mem_wb_d;
   mem_wb_t mem_wb_q;

   always_comb begin
      mem_wb_d = bubble_i ? mem_wb_t'('0) : d_i;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wb_q <= '0;
      end else begin
         mem_wb_q <= mem_wb_d;
      end
   end

   assign q_o = mem_wb_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues each data-memory access exactly once, stalls
// upstream until it completes, and flags misaligned accesses and timeouts.
module mem_stage_ctrl
   import wisc_pkg::*;
#(
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr_i,
   input  logic [15:0] wdata_i,
   input  logic [2:0]  write_sel_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic        mem_en_i,
   input  logic        reg_write_i,
   input  logic        mem_reg_i,
   input  logic        halt_i,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_rd_o,
   output logic        mem_wr_o,
   input  logic        mem_stall_i,
   input  logic        mem_done_i,
   input  logic [15:0] mem_rdata_i,
   output logic        stall_o,
   output logic [15:0] wb_rdata_o,
   output logic [15:0] wb_alu_o,
   output logic [2:0]  wb_reg_o,
   output logic        wb_reg_write_o,
   output logic        wb_mem_reg_o,
   output logic        wb_halt_o,
   output logic        err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   state_e     state_d, state_q;
   logic [CNT_W-1:0] wait_cnt_d, wait_cnt_q;

   logic    req, mis, go;
   logic    bubble;
   mem_wb_t wb_d;
   mem_wb_t wb_q;

   assign req = mem_en_i & (mem_read_i | mem_write_i);
   assign mis = req & addr_i[0];
   assign go  = req & ~mis;

   assign mem_addr_o  = addr_i;
   assign mem_wdata_o = wdata_i;

   // NOTE: every signal written here gets a default first, so no path through
   // the case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_rd_o   = 1'b0;
      mem_wr_o   = 1'b0;
      stall_o    = 1'b0;
      bubble     = 1'b0;
      wb_d       = '{rdata:     16'h0000,
                     alu:       addr_i,
                     dst:       write_sel_i,
                     reg_write: reg_write_i,
                     mem_reg:   mem_reg_i,
                     halt:      halt_i,
                     err:       1'b0};

      case (state_q)
         ST_IDLE: begin
            wait_cnt_d = '0;
            if (mis) begin
               wb_d.err       = 1'b1;
               wb_d.halt      = 1'b1;
               wb_d.reg_write = 1'b0;
            end else if (go) begin
               if (mem_stall_i) begin
                  // Memory refused the request: retry next cycle, done is ignored
                  stall_o = 1'b1;
                  bubble  = 1'b1;
               end else begin
                  mem_rd_o = mem_read_i;
                  mem_wr_o = mem_write_i;
                  if (mem_done_i) begin
                     wb_d.rdata = mem_rdata_i;
                  end else begin
                     stall_o    = 1'b1;
                     bubble     = 1'b1;
                     state_d    = ST_BUSY;
                     wait_cnt_d = CNT_W'(1);
                  end
               end
            end
         end

         ST_BUSY: begin
            if (mem_done_i) begin
               wb_d.rdata = mem_rdata_i;
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
               wb_d.err       = 1'b1;
               wb_d.halt      = 1'b1;
               wb_d.reg_write = 1'b0;
               state_d        = ST_IDLE;
               wait_cnt_d     = '0;
            end else begin
               stall_o    = 1'b1;
               bubble     = 1'b1;
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   pipe_MEM_WB u_pipe_mem_wb (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (bubble),
      .d_i      (wb_d),
      .q_o      (wb_q)
   );

   assign wb_rdata_o     = wb_q.rdata;
   assign wb_alu_o       = wb_q.alu;
   assign wb_reg_o       = wb_q.dst;
   assign wb_reg_write_o = wb_q.reg_write;
   assign wb_mem_reg_o   = wb_q.mem_reg;
   assign wb_halt_o      = wb_q.halt;
   assign err_o          = wb_q.err;

endmodule
